// File: rtl/perf_counter_bank.sv
// perf_counter_bank: bank of per-event hardware counters with snapshot
// shadows, read out through a valid/ready command/response port.
// Reads of counters wider than the data bus take two beats (low, then high).
// Optional build macro PERF_CNT_SATURATE_EN: counters saturate at all-ones
// instead of wrapping to zero; overflow flags are set in both builds.
module perf_counter_bank #(
    parameter int NUM_EVENTS = 4,
    parameter int CNT_WIDTH  = 48,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  freeze_i,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [IDX_WIDTH-1:0]  cmd_idx,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic [NUM_EVENTS-1:0] ovf_o
);

    localparam logic [1:0] OP_READ      = 2'b00;
    localparam logic [1:0] OP_SNAPSHOT  = 2'b01;
    localparam logic [1:0] OP_CLEAR     = 2'b10;
    localparam logic [1:0] OP_CLEAR_ALL = 2'b11;

    localparam bit TWO_BEATS = (CNT_WIDTH > DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSP_LO = 2'd1,
        RSP_HI = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_WIDTH-1:0]    counter [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]    shadow  [NUM_EVENTS];
    logic [IDX_WIDTH-1:0]    rd_idx;
    logic                    cmd_accept;
    logic [NUM_EVENTS-1:0]   clear_hit;
    logic [CNT_WIDTH-1:0]    shadow_sel;
    logic [2*DATA_WIDTH-1:0] shadow_ext;
    logic [DATA_WIDTH-1:0]   beat_lo;
    logic [DATA_WIDTH-1:0]   beat_hi;

    // cmd_ready depends on the state register only, never on cmd_valid.
    assign cmd_ready  = (state == IDLE);
    assign cmd_accept = cmd_valid && cmd_ready;

    // Per-channel clear strobe; an out-of-range CLEAR index matches no channel.
    always_comb begin
        clear_hit = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (cmd_accept && cmd_op == OP_CLEAR_ALL) begin
                clear_hit[i] = 1'b1;
            end else if (cmd_accept && cmd_op == OP_CLEAR && cmd_idx == IDX_WIDTH'(i)) begin
                clear_hit[i] = 1'b1;
            end
        end
    end

    // Event counters and sticky overflow flags; a clear beats a same-cycle event.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                counter[i] <= '0;
            end
            ovf_o <= '0;
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (clear_hit[i]) begin
                    counter[i] <= '0;
                    ovf_o[i]   <= 1'b0;
                end else if (event_i[i] && !freeze_i) begin
                    if (counter[i] == {CNT_WIDTH{1'b1}}) begin
                        ovf_o[i] <= 1'b1;
`ifdef PERF_CNT_SATURATE_EN
                        counter[i] <= counter[i];
`else
                        counter[i] <= '0;
`endif
                    end else begin
                        counter[i] <= counter[i] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Shadow copies capture the pre-increment counter values on SNAPSHOT.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                shadow[i] <= '0;
            end
        end else if (cmd_accept && cmd_op == OP_SNAPSHOT) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                shadow[i] <= counter[i];
            end
        end
    end

    // Remember which channel a READ targets for the duration of its response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_idx <= '0;
        end else if (cmd_accept && cmd_op == OP_READ) begin
            rd_idx <= cmd_idx;
        end
    end

    // Response FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: READ starts a response, each handshake advances a beat.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_accept && cmd_op == OP_READ) begin
                    state_next = RSP_LO;
                end
            end
            RSP_LO: begin
                if (rsp_ready) begin
                    state_next = TWO_BEATS ? RSP_HI : IDLE;
                end
            end
            RSP_HI: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Select the addressed shadow and split it into zero-extended beats.
    always_comb begin
        shadow_sel = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (rd_idx == IDX_WIDTH'(i)) begin
                shadow_sel = shadow[i];
            end
        end
        shadow_ext                = '0;
        shadow_ext[CNT_WIDTH-1:0] = shadow_sel;
        beat_lo = shadow_ext[DATA_WIDTH-1:0];
        beat_hi = shadow_ext[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    // Response outputs decode from state; data is zero whenever no beat is valid.
    always_comb begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_last  = 1'b0;
        case (state)
            RSP_LO: begin
                rsp_valid = 1'b1;
                rsp_data  = beat_lo;
                rsp_last  = !TWO_BEATS;
            end
            RSP_HI: begin
                rsp_valid = 1'b1;
                rsp_data  = beat_hi;
                rsp_last  = 1'b1;
            end
            default: begin
                rsp_valid = 1'b0;
            end
        endcase
    end

endmodule
